// File: rtl/riscv_arb_mux_pkg.sv
// Shared arbitration-mode encodings, default data width and index-width helper.
package riscv_arb_mux_pkg;
  localparam int XLEN_DEF = 32;
  localparam int ARB_SEL  = 0;
  localparam int ARB_FIX  = 1;
  localparam int ARB_RR   = 2;

  // Index ports stay at least one bit wide so a single-channel build still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/riscv_arb_mux_rr_arbiter.sv
// Request arbiter: fixed priority from index 0, or round-robin from a rotating pointer.
// Latency: grant is combinational; the pointer advances on the edge of a granted update.
// Backpressure: the caller gates upd, so the pointer freezes while the consumer stalls.
module riscv_rr_arbiter
  import riscv_arb_mux_pkg::*;
#(
  parameter int  N_REQ = 3,
  parameter int  MODE  = ARB_RR,
  localparam int IW    = idx_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             upd,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             gnt_vld
);
  logic [IW-1:0] ptr;
  logic          hi_vld;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;

  // Lowest request at or above ptr wins; otherwise wrap to the lowest request overall.
  always_comb begin
    hi_vld  = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    gnt_vld = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        gnt_vld = 1'b1;
        lo_idx  = IW'(k);
        if (k >= int'(ptr)) begin
          hi_vld = 1'b1;
          hi_idx = IW'(k);
        end
      end
    end
    gnt_idx = hi_vld ? hi_idx : lo_idx;
    gnt     = '0;
    for (int k = 0; k < N_REQ; k++)
      gnt[k] = gnt_vld && (gnt_idx == IW'(k));
  end

  if (MODE == ARB_RR) begin : g_ptr
    // Explicit wrap keeps the pointer modulo N_REQ for non-power-of-two channel counts.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        ptr <= '0;
      else if (upd && gnt_vld)
        ptr <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end else begin : g_no_ptr
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, upd};
    assign ptr       = '0;
  end
endmodule

// File: rtl/riscv_arb_mux.sv
// N-channel valid/ready mux into a single registered output stage (select, fixed or RR).
// Latency: 1 cycle from input transfer to o_mux_valid; full throughput when downstream ready.
// Backpressure: a held output with i_mux_ready low drops every o_mux_ready and freezes state.
module riscv_arb_mux
  import riscv_arb_mux_pkg::*;
#(
  parameter int  N_MUX_IN = 3,
  parameter int  XLEN     = XLEN_DEF,
  parameter int  ARB_MODE = ARB_FIX,
  localparam int IW       = idx_w(N_MUX_IN)
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic [IW-1:0]            i_mux_sel,
  input  logic [N_MUX_IN-1:0]      i_mux_valid,
  output logic [N_MUX_IN-1:0]      o_mux_ready,
  input  logic [N_MUX_IN*XLEN-1:0] i_mux_concat_data,
  output logic                     o_mux_valid,
  input  logic                     i_mux_ready,
  output logic [XLEN-1:0]          o_mux_data,
  output logic [IW-1:0]            o_mux_grant_idx
);
  logic                load;
  logic                gnt_vld;
  logic [N_MUX_IN-1:0] gnt;
  logic [IW-1:0]       gnt_idx;
  logic [XLEN-1:0]     gnt_dat;

  assign load = !o_mux_valid || i_mux_ready;

  if (ARB_MODE == ARB_SEL) begin : g_sel
    // Out-of-range select matches no channel, so no grant and no ready.
    always_comb begin
      gnt = '0;
      for (int k = 0; k < N_MUX_IN; k++)
        gnt[k] = (i_mux_sel == IW'(k)) && i_mux_valid[k];
      gnt_vld = |gnt;
      gnt_idx = i_mux_sel;
    end
  end else begin : g_arb
    logic unused_sel;
    assign unused_sel = ^i_mux_sel;

    riscv_rr_arbiter #(
      .N_REQ (N_MUX_IN),
      .MODE  (ARB_MODE)
    ) u_arb (
      .clk     (i_clk),
      .rst_n   (i_rstn),
      .req     (i_mux_valid),
      .upd     (load),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
    );
  end

  always_comb begin
    gnt_dat = '0;
    for (int k = 0; k < N_MUX_IN; k++)
      if (gnt[k]) gnt_dat = i_mux_concat_data[k*XLEN +: XLEN];
  end

  // Ready is held low during reset even though the empty register would otherwise load.
  assign o_mux_ready = (load && i_rstn) ? gnt : '0;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_mux_valid     <= 1'b0;
      o_mux_data      <= '0;
      o_mux_grant_idx <= '0;
    end else if (load) begin
      o_mux_valid <= gnt_vld;
      if (gnt_vld) begin
        o_mux_data      <= gnt_dat;
        o_mux_grant_idx <= gnt_idx;
      end
    end
  end
endmodule

// File: tb/tb_riscv_arb_mux.sv
// Four DUT builds (select N=3, fixed N=3, round-robin N=3, round-robin N=5) against a cycle model.
module tb_riscv_arb_mux;
  localparam int NU = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int cfg_n    [NU] = '{3, 3, 3, 5};
  int cfg_mode [NU] = '{0, 1, 2, 2};

  logic [4:0]  vld  [NU];
  logic [2:0]  sel  [NU];
  logic [31:0] dat  [NU][5];
  logic        drdy [NU];

  logic [4:0]  q_rdy [NU];
  logic        q_vld [NU];
  logic [31:0] q_dat [NU];
  logic [2:0]  q_idx [NU];

  logic [2:0]  r0, r1, r2;
  logic [4:0]  r3;
  logic [1:0]  x0, x1, x2;
  logic [2:0]  x3;
  logic        v0, v1, v2, v3;
  logic [31:0] d0, d1, d2, d3;

  riscv_arb_mux #(.N_MUX_IN(3), .XLEN(32), .ARB_MODE(0)) u_sel (
    .i_clk(clk), .i_rstn(rstn), .i_mux_sel(sel[0][1:0]), .i_mux_valid(vld[0][2:0]),
    .o_mux_ready(r0), .i_mux_concat_data({dat[0][2], dat[0][1], dat[0][0]}),
    .o_mux_valid(v0), .i_mux_ready(drdy[0]), .o_mux_data(d0), .o_mux_grant_idx(x0));

  riscv_arb_mux #(.N_MUX_IN(3), .XLEN(32), .ARB_MODE(1)) u_fix (
    .i_clk(clk), .i_rstn(rstn), .i_mux_sel(sel[1][1:0]), .i_mux_valid(vld[1][2:0]),
    .o_mux_ready(r1), .i_mux_concat_data({dat[1][2], dat[1][1], dat[1][0]}),
    .o_mux_valid(v1), .i_mux_ready(drdy[1]), .o_mux_data(d1), .o_mux_grant_idx(x1));

  riscv_arb_mux #(.N_MUX_IN(3), .XLEN(32), .ARB_MODE(2)) u_rr3 (
    .i_clk(clk), .i_rstn(rstn), .i_mux_sel(sel[2][1:0]), .i_mux_valid(vld[2][2:0]),
    .o_mux_ready(r2), .i_mux_concat_data({dat[2][2], dat[2][1], dat[2][0]}),
    .o_mux_valid(v2), .i_mux_ready(drdy[2]), .o_mux_data(d2), .o_mux_grant_idx(x2));

  riscv_arb_mux #(.N_MUX_IN(5), .XLEN(32), .ARB_MODE(2)) u_rr5 (
    .i_clk(clk), .i_rstn(rstn), .i_mux_sel(sel[3]), .i_mux_valid(vld[3]),
    .o_mux_ready(r3),
    .i_mux_concat_data({dat[3][4], dat[3][3], dat[3][2], dat[3][1], dat[3][0]}),
    .o_mux_valid(v3), .i_mux_ready(drdy[3]), .o_mux_data(d3), .o_mux_grant_idx(x3));

  always_comb begin
    q_rdy[0] = {2'b00, r0}; q_vld[0] = v0; q_dat[0] = d0; q_idx[0] = {1'b0, x0};
    q_rdy[1] = {2'b00, r1}; q_vld[1] = v1; q_dat[1] = d1; q_idx[1] = {1'b0, x1};
    q_rdy[2] = {2'b00, r2}; q_vld[2] = v2; q_dat[2] = d2; q_idx[2] = {1'b0, x2};
    q_rdy[3] = r3;          q_vld[3] = v3; q_dat[3] = d3; q_idx[3] = x3;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: output register contents plus the round-robin pointer per build.
  int          m_ptr [NU];
  logic        m_vld [NU];
  logic [31:0] m_dat [NU];
  int          m_idx [NU];

  function automatic int model_grant(input int u);
    int n;
    int res;
    n   = cfg_n[u];
    res = -1;
    if (cfg_mode[u] == 0) begin
      if (int'(sel[u]) < n && vld[u][sel[u]]) res = int'(sel[u]);
    end else if (cfg_mode[u] == 1) begin
      for (int k = n - 1; k >= 0; k--)
        if (vld[u][k]) res = k;
    end else begin
      for (int j = n - 1; j >= 0; j--)
        if (vld[u][(m_ptr[u] + j) % n]) res = (m_ptr[u] + j) % n;
    end
    return res;
  endfunction

  always @(negedge clk) begin
    int         g;
    logic       ld;
    logic [4:0] er;
    for (int u = 0; u < NU; u++) begin
      if (!rstn) begin
        m_vld[u] = 1'b0; m_dat[u] = '0; m_idx[u] = 0; m_ptr[u] = 0;
      end
      ld = !m_vld[u] || drdy[u];
      g  = model_grant(u);
      er = (rstn && ld && g >= 0) ? 5'(1 << g) : 5'd0;
      check($sformatf("model_ready[%0d]", u), 32'(q_rdy[u]), 32'(er));
      check($sformatf("model_valid[%0d]", u), 32'(q_vld[u]), 32'(m_vld[u]));
      check($sformatf("model_data[%0d]", u), q_dat[u], m_dat[u]);
      check($sformatf("model_idx[%0d]", u), 32'(q_idx[u]), 32'(m_idx[u]));
      if (rstn && ld) begin
        m_vld[u] = (g >= 0);
        if (g >= 0) begin
          m_dat[u] = dat[u][g];
          m_idx[u] = g;
          m_ptr[u] = (g + 1) % cfg_n[u];
        end
      end
    end
  end

  logic [31:0] sb[$];
  logic [2:0]  taken;
  int          seq3 [6] = '{0, 1, 2, 0, 1, 2};
  int          seq5 [4] = '{0, 4, 0, 4};

  initial begin
    for (int u = 0; u < NU; u++) begin
      vld[u] = '0; sel[u] = '0; drdy[u] = 1'b1;
      for (int k = 0; k < 5; k++) dat[u][k] = '0;
    end
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      check("reset_valid", 32'(q_vld[u]), 32'd0);
      check("reset_data", q_dat[u], 32'd0);
      check("reset_idx", 32'(q_idx[u]), 32'd0);
    end
    @(posedge clk); #1 rstn = 1'b1;

    // Explicit select: sel=1 then out-of-range sel=3.
    @(posedge clk); #1;
    dat[0][0] = 32'h1111_1111; dat[0][1] = 32'h2222_2222; dat[0][2] = 32'h3333_3333;
    vld[0] = 5'b00111; sel[0] = 3'd1;
    @(negedge clk);
    check("sel_ready", 32'(q_rdy[0]), 32'h2);
    @(posedge clk); #1 sel[0] = 3'd3;
    @(negedge clk);
    check("sel_data", q_dat[0], 32'h2222_2222);
    check("sel_idx", 32'(q_idx[0]), 32'd1);
    check("sel_oor_ready", 32'(q_rdy[0]), 32'd0);
    @(negedge clk);
    check("sel_drain_valid", 32'(q_vld[0]), 32'd0);
    check("sel_drain_hold", q_dat[0], 32'h2222_2222);
    @(posedge clk); #1 vld[0] = '0;

    // Fixed priority: channel 1 always beats channel 2.
    dat[1][1] = 32'hAAAA_0001; dat[1][2] = 32'hAAAA_0002; vld[1] = 5'b00110;
    @(negedge clk);
    check("fix_ready0", 32'(q_rdy[1]), 32'h2);
    repeat (4) begin
      @(negedge clk);
      check("fix_ready", 32'(q_rdy[1]), 32'h2);
      check("fix_idx", 32'(q_idx[1]), 32'd1);
      check("fix_data", q_dat[1], 32'hAAAA_0001);
    end
    @(posedge clk); #1 vld[1] = '0;

    // Round-robin over three always-valid channels.
    dat[2][0] = 32'hB000_0000; dat[2][1] = 32'hB000_0001; dat[2][2] = 32'hB000_0002;
    vld[2] = 5'b00111;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_seq_idx", 32'(q_idx[2]), 32'(seq3[i]));
      check("rr_seq_valid", 32'(q_vld[2]), 32'd1);
    end
    // Stall: ch0 is captured on this edge, then downstream holds off for 4 cycles.
    @(posedge clk); #1 drdy[2] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("stall_data", q_dat[2], 32'hB000_0000);
      check("stall_ready", 32'(q_rdy[2]), 32'd0);
    end
    @(posedge clk); #1 drdy[2] = 1'b1;
    @(negedge clk);
    check("stall_ptr_frozen", 32'(q_rdy[2]), 32'h2);
    @(posedge clk); #1 vld[2] = '0;
    repeat (2) @(posedge clk);
    #1;

    // Random traffic with held valids and a transfer scoreboard.
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      taken = q_rdy[2][2:0] & vld[2][2:0];
      if (q_vld[2] && drdy[2]) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_underflow: got %h, expected no output", q_dat[2]);
        end else check("sb_data", q_dat[2], sb.pop_front());
      end
      for (int k = 0; k < 3; k++) if (taken[k]) sb.push_back(dat[2][k]);
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        if (!vld[2][k] || taken[k]) begin
          vld[2][k] = (i < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
          dat[2][k] = $urandom;
        end
      end
      drdy[2] = (i < 100) ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    check("sb_empty", 32'(sb.size()), 32'd0);

    // Five channels, RR across the 4 -> 0 wrap.
    for (int k = 0; k < 5; k++) dat[3][k] = 32'hC000_0000 + 32'(k);
    vld[3] = 5'b10001;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr5_idx", 32'(q_idx[3]), 32'(seq5[i]));
    end
    @(posedge clk); #1 vld[3] = '0;

    // Reset during a stall: pointer sits at 1 with ch0 held in the output.
    dat[2][0] = 32'hD000_0000; dat[2][1] = 32'hD000_0001; dat[2][2] = 32'hD000_0002;
    vld[2] = 5'b00001; drdy[2] = 1'b1;
    @(posedge clk); #1 vld[2] = 5'b00111; drdy[2] = 1'b0;
    #2;
    check("rst_pre_valid", 32'(q_vld[2]), 32'd1);
    check("rst_pre_data", q_dat[2], 32'hD000_0000);
    rstn = 1'b0;
    #1;
    check("rst_async_valid", 32'(q_vld[2]), 32'd0);
    check("rst_async_data", q_dat[2], 32'd0);
    check("rst_async_ready", 32'(q_rdy[2]), 32'd0);
    @(negedge clk);
    @(posedge clk); #1 rstn = 1'b1; drdy[2] = 1'b1;
    @(negedge clk);
    check("rst_ptr_zero", 32'(q_rdy[2]), 32'h1);
    @(negedge clk);
    check("rst_first_idx", 32'(q_idx[2]), 32'd0);
    @(posedge clk); #1 vld[2] = '0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
